alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the 4-bit ALU operand/result interface.
- Accepts ALU commands (op, A, B) from an upstream requester over a valid/ready handshake and drives them onto the combinational ALU's op/A/B inputs.
- Captures result, overflow and zero into registers and returns them downstream over a second valid/ready handshake.
- Keeps statistics counters for issued operations and overflow events.

Parameters:
CNT_W, 8, width of the op and overflow statistics counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 NOT, 011 AND, 100 OR, 101 XOR, 110 COMPARE, 111 equal.
- cmd_a  in  4  operand A, two's complement.
- cmd_b  in  4  operand B, two's complement.
- alu_op  out  3  opcode driven to ALU; registered.
- alu_a  out  4  operand A driven to ALU; registered.
- alu_b  out  4  operand B driven to ALU; registered.
- alu_result  in  4  ALU result; combinational from alu_op/alu_a/alu_b.
- alu_overflow  in  1  ALU signed-overflow flag.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  4  captured result.
- rsp_overflow  out  1  captured overflow.
- rsp_zero  out  1  captured zero.
- op_cnt  out  CNT_W  number of completed issues; wraps.
- ovf_cnt  out  CNT_W  number of captured overflows; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - alu_op/alu_a/alu_b = 0.
  - rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_zero=0.
  - op_cnt=0, ovf_cnt=0.
  - Reset mid-operation discards any in-flight command and any pending response.
- FSM states: IDLE, ISSUE, RESP.
- cmd_ready:
  - IDLE: 1.
  - ISSUE: 0.
  - RESP: equals rsp_ready, so a new command can be accepted in the same cycle the response drains.
- Command accept: cmd_valid & cmd_ready at an edge.
  - Latch cmd_op/cmd_a/cmd_b into alu_op/alu_a/alu_b.
  - Next state = ISSUE.
- ISSUE (exactly one cycle):
  - ALU outputs settle combinationally.
  - At the end edge, capture alu_result/alu_overflow/alu_zero into the rsp_* registers.
  - op_cnt += 1; ovf_cnt += alu_overflow, saturating.
  - Next state = RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - On handshake with cmd_valid=1: accept the new command, go to ISSUE, rsp_valid=0 next cycle.
  - On handshake with cmd_valid=0: go to IDLE.
  - No handshake: stay in RESP; cmd_valid is ignored.
- Latency and throughput:
  - Command accepted at edge N → rsp_valid=1 from cycle after edge N+1.
  - Back-to-back best case: one command per 2 cycles.
- alu_op/alu_a/alu_b keep their last values in IDLE and RESP (no toggling).
- Opcode handling: forwarded unmodified.
  - The ALU defines the result: ADD/SUB produce 4-bit signed arithmetic.
  - On overflow the ALU returns result 0, overflow 1, zero 1.
  - Unimplemented opcodes return result 0, zero 1, overflow 0.
  - The block captures whatever the ALU presents and performs no checking.
- Counters:
  - op_cnt wraps from all-ones to 0.
  - ovf_cnt sticks at all-ones.
  - Both update only on the ISSUE end edge.
- Simultaneous events: reset overrides handshakes. A response handshake and a command accept in RESP are both honoured in the same edge.
- No combinational path from cmd_* to rsp_*. The only combinational output path is rsp_ready→cmd_ready.

Test Plan:
- Reset, then ADD a=3 b=4 with rsp_ready=1 → rsp_valid 2 cycles after accept; result=7, overflow=0, zero=0; op_cnt=1.
- ADD a=7 b=1 → result=0, overflow=1, zero=1; ovf_cnt=1. SUB a=-8 (1000) b=1 → result=0, overflow=1; ovf_cnt=2.
- SUB a=5 b=5 → result=0, overflow=0, zero=1. Opcode 011 with any operands → result=0, zero=1, overflow=0.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready=0 and rsp_* stable. Then raise rsp_ready → response drains and the next command is accepted the same edge; its response is valid 2 cycles later.
- Counter limits with CNT_W=2: 5 overflowing ADDs → ovf_cnt stays at 3; op_cnt reads 1 (wrapped).
- Assert rst_n=0 during ISSUE and during RESP → next cycle state IDLE, rsp_valid=0, counters 0, cmd_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the 4-bit ALU operand/result interface. Takes
//   commands (op, A, B) over a valid/ready handshake. It registers them onto
//   the ALU inputs and waits one cycle for the combinational ALU to settle.
//   It then captures result/overflow/zero and returns them over a second
//   valid/ready handshake. It also counts issued ops (wrapping) and overflows
//   (saturating).
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_a/cmd_b         command opcode and operands
//   alu_op/alu_a/alu_b         registered operands to the ALU
//   alu_result/overflow/zero   ALU outputs (combinational from alu_*)
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/overflow/zero   captured ALU outputs
//   op_cnt, ovf_cnt            statistics counters
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no command in flight, ready for a new one
// ISSUE | operands on ALU, capture result at end of this cycle
// RESP  | response valid, waiting for rsp_ready

module alu_issue_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP: begin
        if (rsp_ready) state_nxt = cmd_valid ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; in RESP cmd_ready follows rsp_ready so a new command can be
  // taken on the same edge the response drains.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      ISSUE:   cmd_ready = 1'b0;
      RESP: begin
        cmd_ready = rsp_ready;
        rsp_valid = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Operand registers: only change on accept, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op <= 3'd0;
      alu_a  <= 4'd0;
      alu_b  <= 4'd0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= cmd_a;
      alu_b  <= cmd_b;
    end
  end

  // Response capture and statistics at the end of ISSUE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_result   <= 4'd0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      op_cnt       <= '0;
      ovf_cnt      <= '0;
    end else if (state == ISSUE) begin
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
      op_cnt       <= op_cnt + CNT_W'(1);
      if (alu_overflow && (ovf_cnt != {CNT_W{1'b1}}))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       rsp_ready;

  // main instance (CNT_W=8)
  logic       cmd_ready, rsp_valid, rsp_overflow, rsp_zero;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, rsp_result;
  logic [3:0] alu_result;
  logic       alu_overflow, alu_zero;
  logic [7:0] op_cnt, ovf_cnt;

  // narrow-counter instance (CNT_W=2), shares the stimulus
  logic       u2_cmd_ready, u2_rsp_valid, u2_rsp_overflow, u2_rsp_zero;
  logic [2:0] u2_alu_op;
  logic [3:0] u2_alu_a, u2_alu_b, u2_rsp_result;
  logic [3:0] u2_alu_result;
  logic       u2_alu_overflow, u2_alu_zero;
  logic [1:0] u2_op_cnt, u2_ovf_cnt;

  always #5 clk = ~clk;

  // Reference ALU: ADD/SUB signed with overflow -> {0,ovf=1,zero=1},
  // XOR implemented, all other opcodes treated as unimplemented.
  function automatic logic [5:0] alu_model(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic signed [4:0] s;
    logic [3:0] r;
    s = 5'sd0;
    case (op)
      3'b000: s = $signed({a[3], a}) + $signed({b[3], b});
      3'b001: s = $signed({a[3], a}) - $signed({b[3], b});
      default: s = 5'sd0;
    endcase
    if (op == 3'b000 || op == 3'b001) begin
      if (s > 5'sd7 || s < -5'sd8) return {4'd0, 1'b1, 1'b1};
      r = s[3:0];
      return {r, 1'b0, (r == 4'd0)};
    end
    if (op == 3'b101) begin
      r = a ^ b;
      return {r, 1'b0, (r == 4'd0)};
    end
    return {4'd0, 1'b0, 1'b1};
  endfunction

  always_comb {alu_result, alu_overflow, alu_zero} = alu_model(alu_op, alu_a, alu_b);
  always_comb {u2_alu_result, u2_alu_overflow, u2_alu_zero} =
      alu_model(u2_alu_op, u2_alu_a, u2_alu_b);

  alu_issue_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .op_cnt(op_cnt), .ovf_cnt(ovf_cnt)
  );

  alu_issue_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(u2_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(u2_alu_op), .alu_a(u2_alu_a), .alu_b(u2_alu_b),
    .alu_result(u2_alu_result), .alu_overflow(u2_alu_overflow), .alu_zero(u2_alu_zero),
    .rsp_valid(u2_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(u2_rsp_result), .rsp_overflow(u2_rsp_overflow), .rsp_zero(u2_rsp_zero),
    .op_cnt(u2_op_cnt), .ovf_cnt(u2_ovf_cnt)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[10];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [7:0] exp_op, exp_ovf;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_op  = 8'd0;
    exp_ovf = 8'd0;
  endtask

  task automatic run_vec(input vec_t v);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("idle_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    step();
    cmd_valid = 1'b0;
    chk("issue_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("issue_alu_op",    {5'd0, alu_op}, {5'd0, v.op});
    chk("issue_alu_a",     {4'd0, alu_a},  {4'd0, v.a});
    step();
    if (v.ovf && exp_ovf != 8'hff) exp_ovf++;
    exp_op++;
    chk("resp_valid",    {7'd0, rsp_valid},    8'd1);
    chk("resp_result",   {4'd0, rsp_result},   {4'd0, v.res});
    chk("resp_overflow", {7'd0, rsp_overflow}, {7'd0, v.ovf});
    chk("resp_zero",     {7'd0, rsp_zero},     {7'd0, v.zero});
    chk("op_cnt",        op_cnt,  exp_op);
    chk("ovf_cnt",       ovf_cnt, exp_ovf);
    step();
    chk("drained_rsp_valid", {7'd0, rsp_valid}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b000, 4'd3,    4'd4,    4'd7,    1'b0, 1'b0};
    vecs[1] = '{3'b000, 4'd7,    4'd1,    4'd0,    1'b1, 1'b1};
    vecs[2] = '{3'b001, 4'b1000, 4'd1,    4'd0,    1'b1, 1'b1};
    vecs[3] = '{3'b001, 4'd5,    4'd5,    4'd0,    1'b0, 1'b1};
    vecs[4] = '{3'b011, 4'd6,    4'd3,    4'd0,    1'b0, 1'b1};
    vecs[5] = '{3'b000, 4'b1101, 4'b1100, 4'b1001, 1'b0, 1'b0};
    vecs[6] = '{3'b101, 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0};
    vecs[7] = '{3'b001, 4'd2,    4'd5,    4'b1101, 1'b0, 1'b0};
    vecs[8] = '{3'b000, 4'b1000, 4'b1111, 4'd0,    1'b1, 1'b1};
    vecs[9] = '{3'b001, 4'd0,    4'b1000, 4'd0,    1'b1, 1'b1};

    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    rsp_ready = 1'b0; rst_n = 1'b0;
    step();
    do_reset();

    // reset state
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_rsp_result", {4'd0, rsp_result}, 8'd0);
    chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
    chk("rst_op_cnt", op_cnt, 8'd0);
    chk("rst_ovf_cnt", ovf_cnt, 8'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // backpressure: response held, new command waits, then both on one edge
    rsp_ready = 1'b0;
    cmd_op = 3'b000; cmd_a = 4'd1; cmd_b = 4'd2; cmd_valid = 1'b1;
    step();                       // accept
    cmd_a = 4'd2; cmd_b = 4'd2;   // next command, offered continuously
    step();                       // RESP
    for (int k = 0; k < 5; k++) begin
      chk("bp_cmd_ready", {7'd0, cmd_ready}, 8'd0);
      chk("bp_rsp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("bp_rsp_result", {4'd0, rsp_result}, 8'd3);
      chk("bp_alu_a_hold", {4'd0, alu_a}, 8'd1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_cmd_ready_follow", {7'd0, cmd_ready}, 8'd1);
    step();                       // drain + accept
    cmd_valid = 1'b0;
    chk("bp_issue_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("bp_new_alu_a", {4'd0, alu_a}, 8'd2);
    step();
    chk("bp_new_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("bp_new_result", {4'd0, rsp_result}, 8'd4);
    chk("bp_op_cnt", op_cnt, 8'd12);
    step();

    // counter limits: 5 overflowing ADDs after reset
    do_reset();
    chk("cnt_rst_u2_op", {6'd0, u2_op_cnt}, 8'd0);
    for (int k = 0; k < 5; k++) run_vec('{3'b000, 4'd7, 4'd1, 4'd0, 1'b1, 1'b1});
    chk("cnt_u2_ovf_sat", {6'd0, u2_ovf_cnt}, 8'd3);
    chk("cnt_u2_op_wrap", {6'd0, u2_op_cnt}, 8'd1);
    chk("cnt_u1_ovf", ovf_cnt, 8'd5);

    // reset during ISSUE
    cmd_op = 3'b000; cmd_a = 4'd3; cmd_b = 4'd3; cmd_valid = 1'b1; rsp_ready = 1'b0;
    step();                       // accept -> ISSUE
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_issue_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_issue_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_issue_op_cnt", op_cnt, 8'd0);
    chk("rst_issue_ovf_cnt", ovf_cnt, 8'd0);
    chk("rst_issue_alu_a", {4'd0, alu_a}, 8'd0);

    // reset during RESP
    cmd_valid = 1'b1;
    step();                       // accept
    cmd_valid = 1'b0;
    step();                       // RESP
    chk("pre_rst_resp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("pre_rst_op_cnt", op_cnt, 8'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_resp_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_resp_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_resp_op_cnt", op_cnt, 8'd0);
    chk("rst_resp_result", {4'd0, rsp_result}, 8'd0);
    step();
    chk("rst_resp_stays_idle", {7'd0, rsp_valid}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
